hazard_unit_p: RTL

Parametrised pipeline hazard unit for the 5-stage core, sitting beside the IF/ID and ID/EX pipeline registers. It detects load-use hazards and inserts a configurable number of bubbles, freezes the whole pipeline while data memory is busy, and flushes wrong-path instructions on an EX-stage redirect. It also keeps a saturating count of bubble cycles for performance monitoring.

---
 rtl/hazard_unit_p.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/hazard_unit_p.sv
// rtl/hazard_unit_p.sv - load-use / memory-busy / redirect hazard unit for the 5-stage core
//
// Purpose:
//   Sits beside the IF/ID and ID/EX pipeline registers. It detects load-use
//   hazards and inserts LOAD_LAT bubbles for each one. It freezes the whole
//   pipeline while data memory is busy. It flushes wrong-path instructions
//   when EX redirects the PC. It also keeps a saturating count of bubble
//   cycles for performance monitoring.
//
// Parameters:
//   REG_W    register-specifier width
//   LOAD_LAT bubbles per load-use hazard (1..15)
//   CNT_W    width of the stall-cycle counter
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst            synchronous active-high reset
//   i_idex_memRead   ID/EX instruction is a load
//   i_idex_rt        destination register of the ID/EX load
//   i_ifid_rs/rt     source specifiers of the IF/ID instruction
//   i_ifid_useRs/Rt  IF/ID instruction really reads rs / rt
//   i_mem_busy       data memory not ready, hold everything
//   i_ex_redirect    taken branch/jump in EX
//   o_ifid_write     IF/ID load enable
//   o_pcWrite        PC load enable
//   o_stall          bubble into ID/EX
//   o_ifid_flush     clear IF/ID to NOP
//   o_idex_flush     clear ID/EX to NOP
//   o_pipe_freeze    hold every pipeline register
//   o_stall_cycles   saturating count of cycles with o_stall=1

module hazard_unit_p #(
  parameter int REG_W    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_idex_memRead,
  input  logic [REG_W-1:0] i_idex_rt,
  input  logic [REG_W-1:0] i_ifid_rs,
  input  logic [REG_W-1:0] i_ifid_rt,
  input  logic             i_ifid_useRs,
  input  logic             i_ifid_useRt,
  input  logic             i_mem_busy,
  input  logic             i_ex_redirect,
  output logic             o_ifid_write,
  output logic             o_pcWrite,
  output logic             o_stall,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_pipe_freeze,
  output logic [CNT_W-1:0] o_stall_cycles
);

  // The memory-busy freeze is an overlay on either state rather than a state.
  typedef enum logic {
    S_IDLE    = 1'b0,
    S_LU_WAIT = 1'b1
  } state_t;

  // Bubbles still owed after the detection cycle.
  localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_n;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_n;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             w_hz;

  assign w_hz = i_idex_memRead &
                ((i_ifid_useRs & (i_ifid_rs == i_idex_rt)) |
                 (i_ifid_useRt & (i_ifid_rt == i_idex_rt)));

  // State register and bubble down-counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // Next state and outputs, in strict priority order.
  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    o_ifid_write  = 1'b1;
    o_pcWrite     = 1'b1;
    o_stall       = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_flush  = 1'b0;
    o_pipe_freeze = 1'b0;

    if (i_rst) begin
      w_state_n = S_IDLE;
      w_cnt_n   = 4'd0;
    end else if (i_mem_busy) begin
      // Everything holds, including the bubble count still owed, so the
      // hazard is simply re-evaluated once memory is ready again.
      o_pipe_freeze = 1'b1;
      o_ifid_write  = 1'b0;
      o_pcWrite     = 1'b0;
    end else if (i_ex_redirect) begin
      // The instruction being stalled is wrong-path: drop the stall.
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
      w_state_n    = S_IDLE;
      w_cnt_n      = 4'd0;
    end else if (r_state == S_LU_WAIT) begin
      // ID/EX holds a bubble here, so hz is meaningless and ignored.
      o_ifid_write = 1'b0;
      o_pcWrite    = 1'b0;
      o_stall      = 1'b1;
      w_cnt_n      = r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        w_state_n = S_IDLE;
      end
    end else if (w_hz) begin
      o_ifid_write = 1'b0;
      o_pcWrite    = 1'b0;
      o_stall      = 1'b1;
      if (LOAD_LAT > 1) begin
        w_state_n = S_LU_WAIT;
        w_cnt_n   = LAT_M1;
      end
    end
  end

  // Saturating bubble-cycle counter; o_stall is already 0 while frozen.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cycles <= '0;
    end else if (o_stall && (r_stall_cycles != CNT_MAX)) begin
      r_stall_cycles <= r_stall_cycles + CNT_ONE;
    end
  end

  assign o_stall_cycles = r_stall_cycles;

endmodule
